store_drain_ctrl: RTL
=====================

Name: store_drain_ctrl

Overview:
Sequences retired stores from the store queue into the single D-cache write port. Each retired store is buffered in program order in a small FIFO and issued to the D-cache with a valid/ready handshake. The block waits for write completion, then returns a one-cycle completion pulse carrying the SQ position, which frees that SQ entry. It sits between the store queue's retire outputs and the D-cache.

Parameters:
N_WAY, 2, retire lanes per cycle
N_BUF, 4, drain FIFO depth (power of two, at least N_WAY)
XLEN, 32, address/data width
POS_W, 4, width of the 1-based SQ position tag

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
ret_valid  in  N_WAY  per-lane retired-store valid
ret_addr  in  N_WAY*XLEN  store address
ret_data  in  N_WAY*XLEN  store data
ret_size  in  N_WAY*2  BYTE/HALF/WORD encoding
ret_pos  in  N_WAY*POS_W  1-based SQ slot
free_slots  out  $clog2(N_BUF)+1  N_BUF minus occupancy, used by the ROB to throttle store retirement
dc_req_valid  out  1  write request valid
dc_req_addr  out  XLEN  request address
dc_req_data  out  XLEN  request data
dc_req_size  out  2  request size
dc_req_ready  in  1  cache accepts the request this cycle
dc_resp_done  in  1  accepted write completed
cmp_valid  out  1  completion pulse to the SQ
cmp_pos  out  POS_W  SQ slot just completed
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - FIFO empty, pointers 0, state IDLE.
  - Outputs: free_slots=N_BUF; dc_req_valid/addr/data/size=0; cmp_valid=0; cmp_pos=0; busy=0.
- Enqueue:
  - Lanes with ret_valid set are enqueued in lane order, lane 0 oldest.
  - Valid lanes must be contiguous from lane 0; a non-contiguous pattern is an assertion error, and only the leading contiguous lanes are taken.
  - free_slots is computed combinationally from registered occupancy only; same-cycle enqueue/pop does not affect it.
  - Enqueuing more than free_slots is an assertion error; excess lanes are dropped and occupancy never exceeds N_BUF.
  - Pointers wrap modulo N_BUF. Occupancy is a $clog2(N_BUF)+1-bit counter, so full (count==N_BUF) is distinct from empty.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if the FIFO is non-empty at the clock edge, load the head into the dc_req_* registers, set dc_req_valid, go to REQ.
  - Latency: a store enqueued at edge t into an empty FIFO gives dc_req_valid high after edge t+1.
  - REQ: hold dc_req_* stable while dc_req_ready=0. On dc_req_ready=1, clear dc_req_valid next cycle and go to WAIT. The head entry stays in the FIFO.
  - WAIT: on dc_resp_done=1:
    - pop the head;
    - pulse cmp_valid for exactly one cycle with cmp_pos = head ret_pos;
    - if another entry remains after the pop, load it and go directly to REQ (back-to-back);
    - otherwise go to IDLE.
  - dc_resp_done in IDLE or REQ is ignored (the stray-response case is covered by an assertion).
- At most one write is outstanding. Stores complete strictly in program order.
- Enqueue and pop in the same cycle: occupancy is unchanged and the head/tail updates are independent. This also applies when the FIFO is full.
- Branch flush has no effect: retired stores are architectural and always drain.
- Reset mid-operation: the in-flight request is abandoned and the FIFO is cleared. A late dc_resp_done arriving after reset is ignored because the FSM is in IDLE.
- busy = (count!=0) || (state!=IDLE).

Optional Feature:
STORE_DRAIN_STATS_EN
- Defined: adds two outputs, both cleared on reset and saturating at all-ones:
  - stall_cycles (32 bits): increments each cycle in REQ with dc_req_ready=0;
  - drained_cnt (32 bits): increments on each cmp_valid.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - MEM_SIZE enum (BYTE=0, HALF=1, WORD=2);
  - STORE_DRAIN_ENTRY struct {addr, data, size, pos};
  - DRAIN_STATE enum {IDLE, REQ, WAIT}.
- One natural sub-module: store_drain_fifo, a multi-enqueue, single-pop circular buffer exposing count, head entry and pop.

Test Plan:
- Reset, then ret_valid=01, addr=0x100, data=0xDEADBEEF, size=WORD, pos=3; dc_req_ready=1 → dc_req_valid one cycle after enqueue with addr=0x100, then dc_resp_done 2 cycles later → cmp_valid=1, cmp_pos=3 for one cycle; busy=0 next cycle.
- Two lanes in one cycle (pos=1 addr=0x10, pos=2 addr=0x14), ready always 1, done one cycle after accept → cmp_pos sequence 1 then 2, and the second request issues in the cycle after the first completion (no IDLE bubble).
- Fill 4 entries while dc_req_ready=0 → free_slots reaches 0; dc_req fields stay stable for 10 stall cycles; with STORE_DRAIN_STATS_EN defined, stall_cycles=10.
- FIFO full, then simultaneously enqueue one store and complete one → free_slots stays 0 and the new store completes last with correct pos.
- Write pointer wraps after 6 sequential stores, pos 1..6 → cmp_pos 1..6 in order; drained_cnt=6 with STORE_DRAIN_STATS_EN.
- Reset asserted in WAIT, then dc_resp_done pulses next cycle → no cmp_valid, free_slots=4, dc_req_valid=0.

Source files
------------

// File: rtl/store_drain_pkg.sv
// Shared types for the store drain path: access size encoding, drain entry, FSM states.
package store_drain_pkg;

  localparam int SD_XLEN  = 32;
  localparam int SD_POS_W = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [SD_XLEN-1:0]  addr;
    logic [SD_XLEN-1:0]  data;
    mem_size_e           size;
    logic [SD_POS_W-1:0] pos;
  } store_drain_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } drain_state_e;

endpackage

// File: rtl/store_drain_fifo.sv
// Program-order circular buffer: up to N_WAY enqueues per cycle from lane 0, one pop per cycle.
// Exposes registered occupancy plus the head and the entry behind it for back-to-back issue.
module store_drain_fifo
  import store_drain_pkg::*;
#(
  parameter int N_WAY = 2,
  parameter int N_BUF = 4,
  localparam int PTR_W = $clog2(N_BUF),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic               [N_WAY-1:0]       enq_vld,
  input  store_drain_entry_t [N_WAY-1:0]       enq_dat,
  input  logic                                 pop,
  output logic               [CNT_W-1:0]       count,
  output store_drain_entry_t                   head,
  output store_drain_entry_t                   head_nxt
);

  store_drain_entry_t mem_q [N_BUF];
  store_drain_entry_t mem_d [N_BUF];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
  logic [CNT_W-1:0] count_q, count_d, n_lead, n_take, allowed;
  logic             contig, run;

  always_comb begin
    n_lead = '0;
    run    = 1'b1;
    contig = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      if (enq_vld[i]) begin
        if (run) n_lead = n_lead + CNT_W'(1);
        else     contig = 1'b0;
      end else begin
        run = 1'b0;
      end
    end
    // A pop in the same cycle frees the head slot, so a full buffer can still take one store.
    allowed = (CNT_W'(N_BUF) - count_q) + CNT_W'(pop);
    n_take  = (n_lead > allowed) ? allowed : n_lead;

    mem_d = mem_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (CNT_W'(i) < n_take) mem_d[wr_ptr_q + PTR_W'(i)] = enq_dat[i];
    end
    wr_ptr_d = wr_ptr_q + n_take[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + n_take - CNT_W'(pop);
    nxt_ptr  = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign count    = count_q;
  assign head     = mem_q[rd_ptr_q];
  assign head_nxt = mem_q[nxt_ptr];

`ifndef SYNTHESIS
  a_contiguous_lanes : assert property (@(posedge clock) disable iff (reset) contig);
  a_no_overflow      : assert property (@(posedge clock) disable iff (reset) n_lead <= allowed);
  a_no_empty_pop     : assert property (@(posedge clock) disable iff (reset) pop |-> count_q != '0);
`endif

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains retired stores in program order to the D-cache write port, one write outstanding at a time.
// Optional STORE_DRAIN_STATS_EN adds saturating stall_cycles / drained_cnt counters.
module store_drain_ctrl
  import store_drain_pkg::*;
#(
  parameter int N_WAY = 2,
  parameter int N_BUF = 4,
  parameter int XLEN  = SD_XLEN,
  parameter int POS_W = SD_POS_W,
  localparam int CNT_W = $clog2(N_BUF) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_WAY-1:0]         ret_valid,
  input  logic [N_WAY*XLEN-1:0]    ret_addr,
  input  logic [N_WAY*XLEN-1:0]    ret_data,
  input  logic [N_WAY*2-1:0]       ret_size,
  input  logic [N_WAY*POS_W-1:0]   ret_pos,
  output logic [CNT_W-1:0]         free_slots,
  output logic                     dc_req_valid,
  output logic [XLEN-1:0]          dc_req_addr,
  output logic [XLEN-1:0]          dc_req_data,
  output logic [1:0]               dc_req_size,
  input  logic                     dc_req_ready,
  input  logic                     dc_resp_done,
  output logic                     cmp_valid,
  output logic [POS_W-1:0]         cmp_pos,
  output logic                     busy
`ifdef STORE_DRAIN_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              drained_cnt
`endif
);

  store_drain_entry_t [N_WAY-1:0] ret_ent;
  store_drain_entry_t             head, head_nxt, req_q, req_d;
  drain_state_e                   state_q, state_d;
  logic [CNT_W-1:0]               count;
  logic                           req_vld_q, req_vld_d, cmp_vld_q, cmp_vld_d, pop;
  logic [POS_W-1:0]               cmp_pos_q, cmp_pos_d;

  always_comb begin
    ret_ent = '0;
    for (int i = 0; i < N_WAY; i++) begin
      ret_ent[i].addr = ret_addr[i*XLEN +: XLEN];
      ret_ent[i].data = ret_data[i*XLEN +: XLEN];
      ret_ent[i].size = mem_size_e'(ret_size[i*2 +: 2]);
      ret_ent[i].pos  = ret_pos[i*POS_W +: POS_W];
    end
  end

  store_drain_fifo #(.N_WAY(N_WAY), .N_BUF(N_BUF)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .enq_vld  (ret_valid),
    .enq_dat  (ret_ent),
    .pop      (pop),
    .count    (count),
    .head     (head),
    .head_nxt (head_nxt)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    req_vld_d = req_vld_q;
    cmp_vld_d = 1'b0;
    cmp_pos_d = cmp_pos_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: if (count != '0) begin
        req_d     = head;
        req_vld_d = 1'b1;
        state_d   = REQ;
      end
      REQ: if (dc_req_ready) begin
        req_vld_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: if (dc_resp_done) begin
        // Head stays buffered until the write completes so its SQ slot is only freed then.
        pop       = 1'b1;
        cmp_vld_d = 1'b1;
        cmp_pos_d = head.pos;
        if (count > CNT_W'(1)) begin
          req_d     = head_nxt;
          req_vld_d = 1'b1;
          state_d   = REQ;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      req_vld_q <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      req_vld_q <= req_vld_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_pos_q <= cmp_pos_d;
    end
  end

  assign free_slots   = CNT_W'(N_BUF) - count;
  assign dc_req_valid = req_vld_q;
  assign dc_req_addr  = req_q.addr;
  assign dc_req_data  = req_q.data;
  assign dc_req_size  = req_q.size;
  assign cmp_valid    = cmp_vld_q;
  assign cmp_pos      = cmp_pos_q;
  assign busy         = (count != '0) || (state_q != IDLE);

`ifdef STORE_DRAIN_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, drained_cnt_q, drained_cnt_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    drained_cnt_d  = drained_cnt_q;
    if (state_q == REQ && !dc_req_ready && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 32'd1;
    if (cmp_vld_d && drained_cnt_q != '1) drained_cnt_d = drained_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      drained_cnt_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      drained_cnt_q  <= drained_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign drained_cnt  = drained_cnt_q;
`endif

`ifndef SYNTHESIS
  // A completion landing one cycle after reset is a leftover from the abandoned write.
  a_no_stray_resp : assert property (@(posedge clock) disable iff (reset)
                                     (dc_resp_done && !$past(reset)) |-> state_q == WAIT);
`endif

endmodule
